ma_store_buffer_stage: RTL and testbench
========================================

# ma_store_buffer_stage

Memory-access pipeline stage with a parametrised in-order store buffer between EX and WB. Stores retire from the stage into a DEPTH-entry FIFO and drain to the data-memory write port on a valid/ready handshake, so a slow write no longer stalls the pipe. Loads issue directly, but are held while the buffer contains a store to the same word (read-after-write ordering). Store byte-lane formatting (sw/sb/sh/swl/swr) is done on entry to the buffer.

## Interface
- DEPTH, 4, store-buffer entries; power of two, ≥2
- PAYLOAD_W, 64, width of opaque pass-through bits (rf/WB control, PC, exception info)
- clk  in  1  clock; all state changes on rising edge
- rst_p  in  1  synchronous, active-high reset
- flush  in  1  exception/eret flush: kill stage contents; buffer untouched
- EX_ready  in  1  EX holds a valid instruction for this stage
- MA_enable  out  1  stage can accept this cycle
- addr_in  in  32  effective address (ALU result)
- store_data_in  in  32  rt value for stores
- mem_read_in, mem_write_in  in  1 each  load / store
- align_store_in  in  5  one-hot {sw,sb,sh,swl,swr}; zero for non-stores
- payload_in  in  PAYLOAD_W  pass-through
- MA_ready  out  1  stage holds an instruction able to leave
- WB_enable  in  1  WB can accept
- addr_out  out  32, mem_read_out  out  1, payload_out  out  PAYLOAD_W  registered stage contents
- valid_out  out  1  stage register valid
- MA_mem_read  out  1, MA_mem_raddr  out  32  load request, {addr[31:2],2'b00}
- mem_wvalid  out  1, mem_wready  in  1  buffer-head write handshake
- mem_waddr  out  32, mem_wstrb  out  4, mem_wdata  out  32  head entry
- sb_count  out  $clog2(DEPTH)+1  occupancy
- sb_empty  out  1  count == 0

## Operation
- comming = MA_enable && EX_ready; leaving = WB_enable && MA_ready.
- valid: rst_p or flush → 0; else comming → 1; else leaving → 0. MA_enable = !valid || leaving.
- Stage registers load on comming only; hold otherwise.
- full = (sb_count == DEPTH). match = any valid buffer entry whose waddr[31:2] == addr[31:2] (head being popped this cycle still counts).
- MA_ready = valid && !flush && !(mem_write && full) && !(mem_read && match).
- Store: on leaving with mem_write, push {addr[31:2],2'b00}, strobe, data. Push is blocked when full even if a pop occurs that cycle (no comb path from mem_wready to MA_ready).
- Load: MA_mem_read = mem_read && leaving; MA_mem_raddr word-aligned.
- Formatting, a = addr[1:0], B = store data: sw → 1111, B. sb → 1<<a, B<<8a. sh → a[1]?1100:0011, B<<16a[1]. swl → a=0:0001,1:0011,2:0111,3:1111; B>>8(3−a). swr → a=0:1111,1:1110,2:1100,3:1000; B<<8a. Non-one-hot align_store: OR of selected terms (undefined ISA case, no check).
- Drain: mem_wvalid = !sb_empty; mem_w* show head. Pop on mem_wvalid && mem_wready. Push and pop in same cycle: count unchanged, pointers both advance.
- Pointers: $clog2(DEPTH)-bit, wrap modulo DEPTH; count tracks full/empty.
- flush does not drop buffered stores (already committed); a store in the stage at flush is dropped (not pushed).
- mem_wdata/waddr/wstrb stable while mem_wvalid && !mem_wready.

## Timing
- Reset: valid_out=0, MA_ready=0, MA_enable=1, MA_mem_read=0, mem_wvalid=0, sb_count=0, sb_empty=1; addr_out/payload_out/mem_waddr/mem_wdata/mem_wstrb unspecified (no reset on datapath). Reset mid-drain discards all entries.
- Pipeline latency 1 cycle EX→WB when unstalled; full throughput, one instruction per cycle.
- Pushed entry appears on mem_w* at the next edge at earliest (store→mem_wvalid ≥1 cycle).
- Load held by match: MA_ready rises the cycle after the last matching entry pops.
- Full buffer with store in stage: MA_ready rises the cycle after a pop.
- Drain rate ≤1 entry/cycle.

## Test plan
- Reset then 3 sw to 0x100,0x104,0x108 with mem_wready=1 → each leaves in 1 cycle; writes appear in order, wstrb=1111, sb_count peaks ≤1.
- mem_wready=0, DEPTH=4, 5 back-to-back sb → 4 pushed, 5th stalls MA_ready=0, sb_count=4; raise mem_wready → 5th leaves one cycle after first pop.
- sb B=0x000000AB to 0x203 → wstrb=1000, wdata=0xAB000000; swl B=0x11223344 to 0x201 → 0011, 0x00001122; swr to 0x201 → 1110, 0x22334400.
- Buffer holds sw 0x300, mem_wready=0, lw 0x302 in stage → MA_ready=0, MA_mem_read=0; release wready → lw leaves the cycle after the pop, MA_mem_raddr=0x300. lw 0x304 not held.
- flush with sw in stage and 2 buffered entries → stage valid=0, nothing pushed, both entries still drain.
- rst_p asserted with 3 entries pending → next cycle sb_count=0, mem_wvalid=0, MA_enable=1.

Source files
------------

// File: rtl/ma_store_buffer_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : ma_store_buffer_stage_if
// Brief    : Data-memory side of the MA stage: load request and the
//            store-buffer drain write handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface ma_store_buffer_stage_if;
    logic        MA_mem_read;
    logic [31:0] MA_mem_raddr;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_waddr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;

    modport master (
        output MA_mem_read,
        output MA_mem_raddr,
        output mem_wvalid,
        output mem_waddr,
        output mem_wstrb,
        output mem_wdata,
        input  mem_wready
    );

    modport slave (
        input  MA_mem_read,
        input  MA_mem_raddr,
        input  mem_wvalid,
        input  mem_waddr,
        input  mem_wstrb,
        input  mem_wdata,
        output mem_wready
    );
endinterface
`default_nettype wire

// File: rtl/ma_store_buffer_stage.sv
`default_nettype none
// ============================================================================
// Module   : ma_store_buffer_stage
// Brief    : Memory-access stage with an in-order DEPTH-entry store buffer;
//            loads are held while a buffered store targets the same word.
// Revision : 1.0 - initial release
// ============================================================================
module ma_store_buffer_stage #(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 64
) (
    input  logic                       clk,
    input  logic                       rst_p,
    input  logic                       flush,
    input  logic                       EX_ready,
    output logic                       MA_enable,
    input  logic [31:0]                addr_in,
    input  logic [31:0]                store_data_in,
    input  logic                       mem_read_in,
    input  logic                       mem_write_in,
    input  logic [4:0]                 align_store_in,
    input  logic [PAYLOAD_W-1:0]       payload_in,
    output logic                       MA_ready,
    input  logic                       WB_enable,
    output logic [31:0]                addr_out,
    output logic                       mem_read_out,
    output logic [PAYLOAD_W-1:0]       payload_out,
    output logic                       valid_out,
    output logic [$clog2(DEPTH):0]     sb_count,
    output logic                       sb_empty,
    ma_store_buffer_stage_if.master    mem
);

    localparam int                c_PTR_W   = $clog2(DEPTH);
    localparam int                c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEPTH);

    // Stage registers
    logic                 r_valid;
    logic [31:0]          r_addr;
    logic [31:0]          r_store_data;
    logic                 r_mem_read;
    logic                 r_mem_write;
    logic [4:0]           r_align;
    logic [PAYLOAD_W-1:0] r_payload;

    // Store buffer
    logic [29:0]          r_sb_addr [DEPTH];
    logic [3:0]           r_sb_strb [DEPTH];
    logic [31:0]          r_sb_data [DEPTH];
    logic [DEPTH-1:0]     r_ent_valid;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_comming;
    logic                 w_leaving;
    logic                 w_full;
    logic                 w_match;
    logic [DEPTH-1:0]     w_hit;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_wvalid;
    logic [3:0]           w_strb;
    logic [31:0]          w_data;
    logic [1:0]           w_a;

    // Handshake
    assign w_full    = (r_count == c_CNT_MAX);
    assign w_match   = |w_hit;
    assign MA_ready  = r_valid && !flush
                       && !(r_mem_write && w_full)
                       && !(r_mem_read && w_match);
    assign w_leaving = WB_enable && MA_ready;
    assign MA_enable = !r_valid || w_leaving;
    assign w_comming = MA_enable && EX_ready;

    assign w_wvalid  = (r_count != '0);
    assign w_push    = w_leaving && r_mem_write;
    assign w_pop     = w_wvalid && mem.mem_wready;

    // The head entry is included even when it pops this cycle, so a held load
    // is released one cycle after the last matching store has drained.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign w_hit[gi] = r_ent_valid[gi] && (r_sb_addr[gi] == r_addr[31:2]);
        end
    endgenerate

    // Byte-lane formatting; a non-one-hot select ORs the selected terms.
    assign w_a = r_addr[1:0];
    always_comb begin
        w_strb = 4'b0000;
        w_data = 32'h0000_0000;
        if (r_align[4]) begin
            w_strb = w_strb | 4'b1111;
            w_data = w_data | r_store_data;
        end
        if (r_align[3]) begin
            w_strb = w_strb | (4'b0001 << w_a);
            w_data = w_data | (r_store_data << {w_a, 3'b000});
        end
        if (r_align[2]) begin
            w_strb = w_strb | (w_a[1] ? 4'b1100 : 4'b0011);
            w_data = w_data | (r_store_data << {w_a[1], 4'b0000});
        end
        if (r_align[1]) begin
            w_strb = w_strb | (4'b1111 >> (2'd3 - w_a));
            w_data = w_data | (r_store_data >> {(2'd3 - w_a), 3'b000});
        end
        if (r_align[0]) begin
            w_strb = w_strb | (4'b1111 << w_a);
            w_data = w_data | (r_store_data << {w_a, 3'b000});
        end
    end

    // Control state
    always_ff @(posedge clk) begin
        if (rst_p) begin
            r_valid     <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_ent_valid <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_comming) begin
                r_valid <= 1'b1;
            end else if (w_leaving) begin
                r_valid <= 1'b0;
            end

            if (w_pop) begin
                r_rd_ptr              <= r_rd_ptr + c_PTR_ONE;
                r_ent_valid[r_rd_ptr] <= 1'b0;
            end
            if (w_push) begin
                r_wr_ptr              <= r_wr_ptr + c_PTR_ONE;
                r_ent_valid[r_wr_ptr] <= 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Datapath, no reset
    always_ff @(posedge clk) begin
        if (w_comming) begin
            r_addr       <= addr_in;
            r_store_data <= store_data_in;
            r_mem_read   <= mem_read_in;
            r_mem_write  <= mem_write_in;
            r_align      <= align_store_in;
            r_payload    <= payload_in;
        end
        if (w_push) begin
            r_sb_addr[r_wr_ptr] <= r_addr[31:2];
            r_sb_strb[r_wr_ptr] <= w_strb;
            r_sb_data[r_wr_ptr] <= w_data;
        end
    end

    assign addr_out         = r_addr;
    assign mem_read_out     = r_mem_read;
    assign payload_out      = r_payload;
    assign valid_out        = r_valid;
    assign sb_count         = r_count;
    assign sb_empty         = (r_count == '0);

    assign mem.MA_mem_read  = r_mem_read && w_leaving;
    assign mem.MA_mem_raddr = {r_addr[31:2], 2'b00};
    assign mem.mem_wvalid   = w_wvalid;
    assign mem.mem_waddr    = {r_sb_addr[r_rd_ptr], 2'b00};
    assign mem.mem_wstrb    = r_sb_strb[r_rd_ptr];
    assign mem.mem_wdata    = r_sb_data[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_ma_store_buffer_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ma_store_buffer_stage
// Brief    : Directed self-checking bench for ma_store_buffer_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ma_store_buffer_stage;

    localparam int c_DEPTH = 4;
    localparam int c_PW    = 64;
    localparam logic [4:0] c_SW  = 5'b10000;
    localparam logic [4:0] c_SB  = 5'b01000;
    localparam logic [4:0] c_SH  = 5'b00100;
    localparam logic [4:0] c_SWL = 5'b00010;
    localparam logic [4:0] c_SWR = 5'b00001;

    logic            clk = 1'b0;
    logic            rst_p;
    logic            flush;
    logic            EX_ready;
    logic            MA_enable;
    logic [31:0]     addr_in;
    logic [31:0]     store_data_in;
    logic            mem_read_in;
    logic            mem_write_in;
    logic [4:0]      align_store_in;
    logic [c_PW-1:0] payload_in;
    logic            MA_ready;
    logic            WB_enable;
    logic [31:0]     addr_out;
    logic            mem_read_out;
    logic [c_PW-1:0] payload_out;
    logic            valid_out;
    logic [2:0]      sb_count;
    logic            sb_empty;

    int passed = 0;
    int total  = 0;

    ma_store_buffer_stage_if mif ();

    ma_store_buffer_stage #(.DEPTH(c_DEPTH), .PAYLOAD_W(c_PW)) dut (
        .clk            (clk),
        .rst_p          (rst_p),
        .flush          (flush),
        .EX_ready       (EX_ready),
        .MA_enable      (MA_enable),
        .addr_in        (addr_in),
        .store_data_in  (store_data_in),
        .mem_read_in    (mem_read_in),
        .mem_write_in   (mem_write_in),
        .align_store_in (align_store_in),
        .payload_in     (payload_in),
        .MA_ready       (MA_ready),
        .WB_enable      (WB_enable),
        .addr_out       (addr_out),
        .mem_read_out   (mem_read_out),
        .payload_out    (payload_out),
        .valid_out      (valid_out),
        .sb_count       (sb_count),
        .sb_empty       (sb_empty),
        .mem            (mif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic rd, input logic wr, input logic [4:0] al);
        EX_ready       = v;
        addr_in        = a;
        store_data_in  = d;
        mem_read_in    = rd;
        mem_write_in   = wr;
        align_store_in = al;
        payload_in     = {32'hCAFE_0000, a};
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && !sb_empty; i++) tick();
        #1;
        chk(tag, 64'(sb_empty), 64'd1);
    endtask

    initial begin
        rst_p = 1'b1; flush = 1'b0; WB_enable = 1'b1; mif.mem_wready = 1'b0;
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'b0);
        tick(); tick();
        chk("rst_valid",   64'(valid_out),       64'd0);
        chk("rst_ready",   64'(MA_ready),        64'd0);
        chk("rst_enable",  64'(MA_enable),       64'd1);
        chk("rst_mrd",     64'(mif.MA_mem_read), 64'd0);
        chk("rst_wvalid",  64'(mif.mem_wvalid),  64'd0);
        chk("rst_count",   64'(sb_count),        64'd0);
        chk("rst_empty",   64'(sb_empty),        64'd1);
        rst_p = 1'b0;

        // Three word stores flowing straight through
        mif.mem_wready = 1'b1;
        drv(1'b1, 32'h100, 32'hA1, 1'b0, 1'b1, c_SW); tick();
        drv(1'b1, 32'h104, 32'hA2, 1'b0, 1'b1, c_SW); #1;
        chk("sw_ready",    64'(MA_ready),  64'd1);
        chk("sw_addr_out", 64'(addr_out),  64'h100);
        chk("sw_payload",  payload_out,    64'hCAFE_0000_0000_0100);
        chk("sw_enable",   64'(MA_enable), 64'd1);
        tick();
        drv(1'b1, 32'h108, 32'hA3, 1'b0, 1'b1, c_SW); #1;
        chk("sw1_wvalid",  64'(mif.mem_wvalid), 64'd1);
        chk("sw1_waddr",   64'(mif.mem_waddr),  64'h100);
        chk("sw1_wstrb",   64'(mif.mem_wstrb),  64'hF);
        chk("sw1_wdata",   64'(mif.mem_wdata),  64'hA1);
        chk("sw1_count",   64'(sb_count),       64'd1);
        tick();
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'b0); #1;
        chk("sw2_waddr",   64'(mif.mem_waddr),  64'h104);
        chk("sw2_count",   64'(sb_count),       64'd1);
        tick();
        chk("sw3_waddr",   64'(mif.mem_waddr),  64'h108);
        chk("sw3_valid",   64'(valid_out),      64'd0);
        tick();
        chk("sw_empty",    64'(sb_empty),       64'd1);

        // Fill the buffer with byte stores while the write port is stalled
        mif.mem_wready = 1'b0;
        drv(1'b1, 32'h203, 32'hAB, 1'b0, 1'b1, c_SB); tick();
        drv(1'b1, 32'h210, 32'hAB, 1'b0, 1'b1, c_SB); tick();
        chk("sb_waddr",    64'(mif.mem_waddr),  64'h200);
        chk("sb_wstrb",    64'(mif.mem_wstrb),  64'h8);
        chk("sb_wdata",    64'(mif.mem_wdata),  64'hAB00_0000);
        drv(1'b1, 32'h220, 32'hAB, 1'b0, 1'b1, c_SB); tick();
        drv(1'b1, 32'h230, 32'hAB, 1'b0, 1'b1, c_SB); tick();
        drv(1'b1, 32'h240, 32'hAB, 1'b0, 1'b1, c_SB); tick();
        chk("full_count",  64'(sb_count),  64'd4);
        chk("full_ready",  64'(MA_ready),  64'd0);
        chk("full_enable", 64'(MA_enable), 64'd0);
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'b0); tick();
        chk("full_hold",   64'(MA_ready),          64'd0);
        chk("full_stable", 64'(mif.mem_waddr),     64'h200);
        mif.mem_wready = 1'b1; #1;
        chk("full_nocomb", 64'(MA_ready),          64'd0);
        tick();
        chk("pop_count",   64'(sb_count),          64'd3);
        chk("pop_ready",   64'(MA_ready),          64'd1);
        chk("pop_waddr",   64'(mif.mem_waddr),     64'h210);
        mif.mem_wready = 1'b0; tick();
        chk("push5_count", 64'(sb_count),  64'd4);
        chk("push5_valid", 64'(valid_out), 64'd0);
        mif.mem_wready = 1'b1;
        drain("sb_drain");

        // swl / swr / sh lane formatting
        mif.mem_wready = 1'b0;
        drv(1'b1, 32'h201, 32'h1122_3344, 1'b0, 1'b1, c_SWL); tick();
        drv(1'b1, 32'h201, 32'h1122_3344, 1'b0, 1'b1, c_SWR); tick();
        chk("swl_wstrb",   64'(mif.mem_wstrb), 64'h3);
        chk("swl_wdata",   64'(mif.mem_wdata), 64'h0000_1122);
        drv(1'b1, 32'h202, 32'h0000_BEEF, 1'b0, 1'b1, c_SH); tick();
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'b0); tick();
        chk("fmt_count",   64'(sb_count),      64'd3);
        mif.mem_wready = 1'b1; tick();
        chk("swr_wstrb",   64'(mif.mem_wstrb), 64'hE);
        chk("swr_wdata",   64'(mif.mem_wdata), 64'h2233_4400);
        tick();
        chk("sh_wstrb",    64'(mif.mem_wstrb), 64'hC);
        chk("sh_wdata",    64'(mif.mem_wdata), 64'hBEEF_0000);
        drain("fmt_drain");

        // Load held behind a store to the same word
        mif.mem_wready = 1'b0;
        drv(1'b1, 32'h300, 32'h55, 1'b0, 1'b1, c_SW); tick();
        drv(1'b1, 32'h302, 32'h0, 1'b1, 1'b0, 5'b0); tick();
        chk("raw_ready",   64'(MA_ready),        64'd0);
        chk("raw_mrd",     64'(mif.MA_mem_read), 64'd0);
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'b0); tick();
        chk("raw_hold",    64'(MA_ready),        64'd0);
        chk("raw_mrd_out", 64'(mem_read_out),    64'd1);
        mif.mem_wready = 1'b1; #1;
        chk("raw_popcyc",  64'(MA_ready),        64'd0);
        tick();
        chk("raw_release", 64'(MA_ready),         64'd1);
        chk("raw_mrd1",    64'(mif.MA_mem_read),  64'd1);
        chk("raw_raddr",   64'(mif.MA_mem_raddr), 64'h300);
        mif.mem_wready = 1'b0; tick();
        drv(1'b1, 32'h300, 32'h66, 1'b0, 1'b1, c_SW); tick();
        drv(1'b1, 32'h304, 32'h0, 1'b1, 1'b0, 5'b0); tick();
        chk("nraw_count",  64'(sb_count),         64'd1);
        chk("nraw_ready",  64'(MA_ready),         64'd1);
        chk("nraw_raddr",  64'(mif.MA_mem_raddr), 64'h304);
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'b0); tick();
        mif.mem_wready = 1'b1;
        drain("raw_drain");

        // Flush kills the staged store but keeps buffered ones
        mif.mem_wready = 1'b0;
        drv(1'b1, 32'h400, 32'h1, 1'b0, 1'b1, c_SW); tick();
        drv(1'b1, 32'h404, 32'h2, 1'b0, 1'b1, c_SW); tick();
        drv(1'b1, 32'h408, 32'h3, 1'b0, 1'b1, c_SW); tick();
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'b0);
        flush = 1'b1; #1;
        chk("fl_ready",    64'(MA_ready),  64'd0);
        tick();
        flush = 1'b0;
        chk("fl_valid",    64'(valid_out), 64'd0);
        chk("fl_count",    64'(sb_count),  64'd2);
        tick();
        chk("fl_nopush",   64'(sb_count),  64'd2);
        mif.mem_wready = 1'b1; tick();
        chk("fl_waddr",    64'(mif.mem_waddr), 64'h404);
        drain("fl_drain");

        // Reset mid-drain discards everything
        mif.mem_wready = 1'b0;
        drv(1'b1, 32'h500, 32'h1, 1'b0, 1'b1, c_SW); tick();
        drv(1'b1, 32'h504, 32'h2, 1'b0, 1'b1, c_SW); tick();
        drv(1'b1, 32'h508, 32'h3, 1'b0, 1'b1, c_SW); tick();
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'b0); tick();
        chk("pre_rst_cnt", 64'(sb_count), 64'd3);
        rst_p = 1'b1; tick();
        rst_p = 1'b0;
        chk("mr_count",    64'(sb_count),       64'd0);
        chk("mr_wvalid",   64'(mif.mem_wvalid), 64'd0);
        chk("mr_enable",   64'(MA_enable),      64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
